// File: rtl/ahb_picomem_slave.sv
// ahb_picomem_slave: AHB-Lite slave bridging single transfers onto a PicoRV32 native memory port.
// Define AHB_PICOMEM_TIMEOUT_EN to abort stalled memory requests with an ERROR after TIMEOUT_CYCLES.
module ahb_picomem_slave #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 9
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, WDAT, MEM, DONE, ERR1, ERR2} state_t;
  state_t state;
  logic accept, legal, expired;
  logic [3:0] strb;
  logic unused_bits;
  assign unused_bits = &{1'b0, hprot[3:1], htrans[0]};
  assign accept = hsel & htrans[1] & hready & (state == IDLE || state == DONE);
  assign legal = hsize == 3'b000 || (hsize == 3'b001 && !haddr[0]) ||
                 (hsize == 3'b010 && haddr[1:0] == 2'b00);
  // Big-endian lanes: byte address 0 lives in bits 31:24
  assign strb = hsize == 3'b000 ? 4'b1000 >> haddr[1:0] :
                hsize == 3'b001 ? (haddr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
`ifdef AHB_PICOMEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= state == MEM ? cnt + 1'b1 : '0;
  assign expired = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      hreadyout <= 1'b1;
      hresp <= 1'b0;
      hrdata <= '0;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept && !legal) begin
            state <= ERR1;
            hreadyout <= 1'b0;
            hresp <= 1'b1;
          end else if (accept) begin
            state <= hwrite ? WDAT : MEM;
            hreadyout <= 1'b0;
            mem_valid <= !hwrite;
            mem_addr <= {haddr[31:2], 2'b00};
            mem_instr <= ~hprot[0];
            mem_wstrb <= hwrite ? strb : 4'b0000;
          end else begin
            state <= IDLE;
            hreadyout <= 1'b1;
            hresp <= 1'b0;
          end
        end
        WDAT: begin
          state <= MEM;
          mem_wdata <= hwdata;
          mem_valid <= 1'b1;
        end
        MEM: begin
          if (mem_ready) begin
            state <= DONE;
            mem_valid <= 1'b0;
            hreadyout <= 1'b1;
            if (mem_wstrb == 4'b0000) hrdata <= mem_rdata;
          end else if (expired) begin
            state <= ERR1;
            mem_valid <= 1'b0;
            hresp <= 1'b1;
          end
        end
        ERR1: begin
          state <= ERR2;
          hreadyout <= 1'b1;
        end
        ERR2: begin
          state <= IDLE;
          hresp <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_picomem_slave.sv
// tb_ahb_picomem_slave: directed checks of the AHB to PicoRV32 memory bridge.
module tb_ahb_picomem_slave;
  logic clk = 0, resetn = 0;
  logic hsel = 0, hwrite = 0, hready = 1, mem_ready = 0;
  logic [31:0] haddr = 0, hwdata = 0, mem_rdata = 0;
  logic [1:0] htrans = 0;
  logic [2:0] hsize = 0;
  logic [3:0] hprot = 4'b0011;
  logic hreadyout, hresp, mem_valid, mem_instr;
  logic [31:0] hrdata, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  int total = 0, bad = 0;

  ahb_picomem_slave #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .mem_valid(mem_valid),
    .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
    hsel = 1; htrans = 2'b10; haddr = a; hwrite = w; hsize = s;
  endtask

  task bus_idle;
    hsel = 0; htrans = 2'b00;
  endtask

  task test_reset;
    repeat (2) tick;
    total++;
    if ({hreadyout, hresp, mem_valid, mem_instr, mem_wstrb} !== 8'b1000_0000 ||
        hrdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      bad++;
      $display("FAIL reset: hreadyout=%b hresp=%b valid=%b instr=%b wstrb=%b hrdata=%h addr=%h wdata=%h exp 1 0 0 0 0000 all-zero",
               hreadyout, hresp, mem_valid, mem_instr, mem_wstrb, hrdata, mem_addr, mem_wdata);
    end
    resetn = 1;
    tick;
  endtask

  task test_not_selected;
    hsel = 0; htrans = 2'b10; haddr = 32'h4000_0000; hsize = 3'b010;
    tick;
    hsel = 1; htrans = 2'b01;
    tick;
    total++;
    if (hreadyout !== 1 || hresp !== 0 || mem_valid !== 0) begin
      bad++;
      $display("FAIL not_selected: hreadyout=%b hresp=%b valid=%b exp 1 0 0", hreadyout, hresp, mem_valid);
    end
    bus_idle;
  endtask

  task test_read_word;
    hprot = 4'b0011;
    addr_phase(32'h4000_0010, 0, 3'b010);
    tick;
    bus_idle;
    total++;
    if (mem_valid !== 1 || mem_addr !== 32'h4000_0010 || mem_wstrb !== 4'b0000 ||
        hreadyout !== 0 || mem_instr !== 0) begin
      bad++;
      $display("FAIL read_mem: valid=%b addr=%h wstrb=%b hreadyout=%b instr=%b exp 1 40000010 0000 0 0",
               mem_valid, mem_addr, mem_wstrb, hreadyout, mem_instr);
    end
    tick;
    total++;
    if (mem_valid !== 1 || hreadyout !== 0) begin
      bad++;
      $display("FAIL read_wait: valid=%b hreadyout=%b exp 1 0", mem_valid, hreadyout);
    end
    mem_ready = 1; mem_rdata = 32'hCAFE_BABE;
    tick;
    mem_ready = 0;
    total++;
    if (mem_valid !== 0 || hreadyout !== 1 || hresp !== 0 || hrdata !== 32'hCAFE_BABE) begin
      bad++;
      $display("FAIL read_done: valid=%b hreadyout=%b hresp=%b hrdata=%h exp 0 1 0 cafebabe",
               mem_valid, hreadyout, hresp, hrdata);
    end
    tick;
  endtask

  task test_writes;
    logic [31:0] addrs [4] = '{32'h4000_0003, 32'h4000_0001, 32'h4000_0002, 32'h4000_0008};
    logic [2:0] sizes [4] = '{3'b000, 3'b000, 3'b001, 3'b010};
    logic [3:0] strbs [4] = '{4'b0001, 4'b0100, 4'b0011, 4'b1111};
    logic [31:0] datas [4] = '{32'h0000_00AB, 32'h0000_CD00, 32'h0000_1234, 32'hDEAD_BEEF};
    hprot = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      addr_phase(addrs[i], 1, sizes[i]);
      tick;
      bus_idle;
      hwdata = datas[i];
      total++;
      if (hreadyout !== 0 || mem_valid !== 0 || mem_wstrb !== strbs[i]) begin
        bad++;
        $display("FAIL write_wdat[%0d]: hreadyout=%b valid=%b wstrb=%b exp 0 0 %b",
                 i, hreadyout, mem_valid, mem_wstrb, strbs[i]);
      end
      tick;
      hwdata = 32'hFFFF_FFFF;
      total++;
      if (mem_valid !== 1 || mem_wdata !== datas[i] || mem_addr !== {addrs[i][31:2], 2'b00} ||
          mem_instr !== 1) begin
        bad++;
        $display("FAIL write_mem[%0d]: valid=%b wdata=%h addr=%h instr=%b exp 1 %h %h 1",
                 i, mem_valid, mem_wdata, mem_addr, mem_instr, datas[i], {addrs[i][31:2], 2'b00});
      end
      mem_ready = 1; mem_rdata = 32'h1234_5678;
      tick;
      mem_ready = 0;
      total++;
      if (hreadyout !== 1 || hresp !== 0 || mem_valid !== 0 || hrdata !== 32'hCAFE_BABE) begin
        bad++;
        $display("FAIL write_done[%0d]: hreadyout=%b hresp=%b valid=%b hrdata=%h exp 1 0 0 cafebabe",
                 i, hreadyout, hresp, mem_valid, hrdata);
      end
      tick;
    end
    hprot = 4'b0011;
  endtask

  task test_illegal;
    logic [31:0] addrs [3] = '{32'h4000_0001, 32'h4000_0002, 32'h4000_0000};
    logic [2:0] sizes [3] = '{3'b001, 3'b010, 3'b011};
    for (int i = 0; i < 3; i++) begin
      addr_phase(addrs[i], 1, sizes[i]);
      tick;
      bus_idle;
      total++;
      if (hreadyout !== 0 || hresp !== 1 || mem_valid !== 0) begin
        bad++;
        $display("FAIL err1[%0d]: hreadyout=%b hresp=%b valid=%b exp 0 1 0", i, hreadyout, hresp, mem_valid);
      end
      addr_phase(32'h4000_0010, 0, 3'b010);
      tick;
      bus_idle;
      total++;
      if (hreadyout !== 1 || hresp !== 1 || mem_valid !== 0) begin
        bad++;
        $display("FAIL err2[%0d]: hreadyout=%b hresp=%b valid=%b exp 1 1 0", i, hreadyout, hresp, mem_valid);
      end
      tick;
      total++;
      if (hreadyout !== 1 || hresp !== 0 || mem_valid !== 0) begin
        bad++;
        $display("FAIL err_end[%0d]: hreadyout=%b hresp=%b valid=%b exp 1 0 0", i, hreadyout, hresp, mem_valid);
      end
    end
  endtask

  task test_back_to_back;
    hprot = 4'b0010;
    addr_phase(32'h4000_0020, 0, 3'b010);
    tick;
    bus_idle;
    mem_ready = 1; mem_rdata = 32'h1111_1111;
    tick;
    mem_ready = 0;
    addr_phase(32'h4000_0024, 0, 3'b010);
    total++;
    if (hreadyout !== 1 || hrdata !== 32'h1111_1111) begin
      bad++;
      $display("FAIL b2b_first: hreadyout=%b hrdata=%h exp 1 11111111", hreadyout, hrdata);
    end
    tick;
    bus_idle;
    total++;
    if (mem_valid !== 1 || mem_addr !== 32'h4000_0024 || hreadyout !== 0 || mem_instr !== 1) begin
      bad++;
      $display("FAIL b2b_second: valid=%b addr=%h hreadyout=%b instr=%b exp 1 40000024 0 1",
               mem_valid, mem_addr, hreadyout, mem_instr);
    end
    mem_ready = 1; mem_rdata = 32'h2222_2222;
    tick;
    mem_ready = 0;
    total++;
    if (hrdata !== 32'h2222_2222 || hreadyout !== 1) begin
      bad++;
      $display("FAIL b2b_done: hrdata=%h hreadyout=%b exp 22222222 1", hrdata, hreadyout);
    end
    tick;
    hprot = 4'b0011;
  endtask

  task test_reset_mid;
    addr_phase(32'h4000_0030, 0, 3'b010);
    tick;
    bus_idle;
    #2 resetn = 0;
    #1;
    total++;
    if (mem_valid !== 0 || hreadyout !== 1 || hrdata !== 0) begin
      bad++;
      $display("FAIL reset_async: valid=%b hreadyout=%b hrdata=%h exp 0 1 0", mem_valid, hreadyout, hrdata);
    end
    resetn = 1;
    tick;
    addr_phase(32'h4000_0034, 0, 3'b010);
    tick;
    bus_idle;
    mem_ready = 1; mem_rdata = 32'h5A5A_0F0F;
    tick;
    mem_ready = 0;
    total++;
    if (hrdata !== 32'h5A5A_0F0F || hreadyout !== 1 || mem_addr !== 32'h4000_0034) begin
      bad++;
      $display("FAIL reset_after: hrdata=%h hreadyout=%b addr=%h exp 5a5a0f0f 1 40000034",
               hrdata, hreadyout, mem_addr);
    end
    tick;
  endtask

  task test_timeout;
    addr_phase(32'h4000_0040, 0, 3'b010);
    tick;
    bus_idle;
`ifdef AHB_PICOMEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_valid !== 1 || hreadyout !== 0) begin
        bad++;
        $display("FAIL to_wait[%0d]: valid=%b hreadyout=%b exp 1 0", i, mem_valid, hreadyout);
      end
      tick;
    end
    total++;
    if (mem_valid !== 0 || hreadyout !== 0 || hresp !== 1) begin
      bad++;
      $display("FAIL to_err1: valid=%b hreadyout=%b hresp=%b exp 0 0 1", mem_valid, hreadyout, hresp);
    end
    tick;
    total++;
    if (hreadyout !== 1 || hresp !== 1) begin
      bad++;
      $display("FAIL to_err2: hreadyout=%b hresp=%b exp 1 1", hreadyout, hresp);
    end
    tick;
`else
    repeat (12) tick;
    total++;
    if (mem_valid !== 1 || hreadyout !== 0 || hresp !== 0) begin
      bad++;
      $display("FAIL no_timeout: valid=%b hreadyout=%b hresp=%b exp 1 0 0", mem_valid, hreadyout, hresp);
    end
    mem_ready = 1;
    tick;
    mem_ready = 0;
    tick;
`endif
    total++;
    if (mem_valid !== 0 || hreadyout !== 1 || hresp !== 0) begin
      bad++;
      $display("FAIL to_end: valid=%b hreadyout=%b hresp=%b exp 0 1 0", mem_valid, hreadyout, hresp);
    end
  endtask

  initial begin
    test_reset;
    test_not_selected;
    test_read_word;
    test_writes;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
